// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART definitions for the TX and RX paths
//   Frame FSM state encoding, frame geometry constants and the
//   clock-divider helper. No ports.
//   Optional feature macro: UART_TX_PARITY_EN (ST_PARITY is only entered
//   by the TX FSM when it is defined).
package uart_pkg;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  // System clocks per line bit, integer-truncated.
  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - synchronous byte FIFO for the UART transmitter
//   clk      in   system clock
//   rst      in   asynchronous active-high reset
//   wr_en    in   push wr_data (ignored while full)
//   wr_data  in   byte to push
//   rd_en    in   pop head byte (ignored while empty)
//   rd_data  out  head byte, valid whenever not empty (show-ahead)
//   count    out  number of stored bytes
//   full     out  count == DEPTH
//   empty    out  count == 0
module uart_tx_fifo #(
  parameter int DEPTH = 8,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  input  logic          rd_en,
  output logic [7:0]    rd_data,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          wr_ok;
  logic          rd_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign wr_ok   = wr_en && !full;
  assign rd_ok   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  // Storage needs no reset: a cleared count makes old contents unreachable.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_fifo_tx.sv
// rtl/uart_fifo_tx.sv - buffered 8N1 UART transmitter (FIFO + divider + frame FSM)
//   i_clk      in   system clock
//   i_reset    in   asynchronous active-high reset
//   i_wr_en    in   write strobe, pushes i_wr_data when not full
//   i_wr_data  in   byte to transmit
//   o_full     out  FIFO holds FIFO_DEPTH bytes
//   o_empty    out  FIFO holds no bytes
//   o_busy     out  frame in progress
//   o_tx_done  out  one-cycle pulse per completed frame
//   o_tx       out  registered serial line, idles high
//   Macro UART_TX_PARITY_EN adds an even-parity bit between data and stop.
module uart_fifo_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_wr_en,
  input  logic [7:0] i_wr_data,
  output logic       o_full,
  output logic       o_empty,
  output logic       o_busy,
  output logic       o_tx_done,
  output logic       o_tx
);

  localparam int CPB     = clks_per_bit(CLK_FREQ, BAUD);
  localparam int CNT_W   = (CPB > 1) ? $clog2(CPB) : 1;
  localparam int FIFO_CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CPB - 1);
  localparam logic [2:0]       BIT_LAST = 3'(DATA_BITS - 1);

  uart_state_e          state, state_n;
  logic [CNT_W-1:0]     cnt, cnt_n;
  logic [2:0]           bit_idx, bit_n;
  logic [DATA_BITS-1:0] shift, shift_n;
  logic                 tx_n;
  logic                 done_n;
  logic                 pop;
  logic                 bit_end;
  logic [7:0]           fifo_rd_data;
  logic [FIFO_CW-1:0]   fifo_count;
`ifdef UART_TX_PARITY_EN
  logic                 parity_q, parity_n;
`endif

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (i_clk),
    .rst     (i_reset),
    .wr_en   (i_wr_en),
    .wr_data (i_wr_data),
    .rd_en   (pop),
    .rd_data (fifo_rd_data),
    .count   (fifo_count),
    .full    (o_full),
    .empty   (o_empty)
  );

  assign o_busy  = (state != ST_IDLE);
  assign bit_end = (cnt == CNT_LAST);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bit_n   = bit_idx;
    shift_n = shift;
    pop     = 1'b0;
    done_n  = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_n = parity_q;
`endif
    case (state)
      ST_IDLE: begin
        if (fifo_count != '0) begin
          pop     = 1'b1;
          shift_n = fifo_rd_data;
          cnt_n   = '0;
          state_n = ST_START;
`ifdef UART_TX_PARITY_EN
          parity_n = ^fifo_rd_data;
`endif
        end
      end
      ST_START: begin
        if (bit_end) begin
          cnt_n   = '0;
          bit_n   = '0;
          state_n = ST_DATA;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          cnt_n   = '0;
          shift_n = {1'b0, shift[DATA_BITS-1:1]};
          if (bit_idx == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
            state_n = ST_PARITY;
`else
            state_n = ST_STOP;
`endif
          end else begin
            bit_n = bit_idx + 1'b1;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_end) begin
          cnt_n   = '0;
          state_n = ST_STOP;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
`endif
      ST_STOP: begin
        if (bit_end) begin
          cnt_n   = '0;
          state_n = ST_IDLE;
          done_n  = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        cnt_n   = '0;
        state_n = ST_IDLE;
      end
    endcase

    // Line level is computed from the next state so the registered o_tx
    // lines up with the state register (o_tx falls the cycle after a pop).
    tx_n = 1'b1;
    case (state_n)
      ST_START:  tx_n = 1'b0;
      ST_DATA:   tx_n = shift_n[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: tx_n = parity_n;
`endif
      default:   tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      o_tx      <= 1'b1;
      o_tx_done <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      bit_idx   <= bit_n;
      shift     <= shift_n;
      o_tx      <= tx_n;
      o_tx_done <= done_n;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_n;
`endif
    end
  end

endmodule

// File: doc/uart_fifo_tx.md
Name: uart_fifo_tx

Overview:
- Transmit-side UART block: buffers bytes written by the design and serialises them 8N1, LSB first, on a single TX line.
- Contains its own baud-tick divider off the system clock, a small synchronous byte FIFO and a frame FSM.
- Sits between message/keyboard-style byte producers and the GPIO TX pin.
- Complements the existing receive path, which shifts received bytes into the display buffer.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- BAUD, 115200, line rate in bits/s.
- CLKS_PER_BIT is derived as CLK_FREQ/BAUD, integer-truncated (434 at defaults).
- FIFO_DEPTH, 8, byte FIFO depth; must be a power of two, ≥2.

Ports:
- i_clk  in  1  system clock; all logic on rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_wr_en  in  1  write strobe; pushes i_wr_data when not full.
- i_wr_data  in  8  byte to transmit.
- o_full  out  1  FIFO holds FIFO_DEPTH bytes.
- o_empty  out  1  FIFO holds 0 bytes.
- o_busy  out  1  high while FSM is not IDLE.
- o_tx_done  out  1  one-cycle pulse per completed frame.
- o_tx  out  1  serial line; registered, idles high.

Behaviour:
- Reset (async assert, sync-safe release):
  - o_tx=1, o_busy=0, o_tx_done=0.
  - FIFO pointers and count cleared, so o_empty=1, o_full=0.
  - FSM goes to IDLE and the baud counter is cleared.
  - Reset mid-frame aborts the frame immediately: o_tx returns high and buffered bytes are discarded.
- FIFO:
  - Write accepted when i_wr_en=1 and o_full=0.
  - A write while full is dropped silently, with no state change.
  - Pop happens only from IDLE.
  - Simultaneous write and pop in one cycle both take effect; count is unchanged.
  - Pointers are log2(FIFO_DEPTH) bits and wrap naturally.
  - Count is log2(FIFO_DEPTH)+1 bits.
  - o_full and o_empty are derived from the registered count.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: o_tx=1. If FIFO not empty, pop the head byte into an 8-bit shift register, clear the baud counter and go to START.
  - START: o_tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: o_tx=shift[0] for CLKS_PER_BIT cycles per bit; shift right after each bit. After bit index 7 completes, go to STOP.
  - STOP: o_tx=1 for CLKS_PER_BIT cycles, then go to IDLE and pulse o_tx_done for exactly that first IDLE cycle.
- Timing:
  - o_tx falls on the cycle after the pop.
  - Back-to-back frames have exactly one idle cycle between them: the IDLE cycle that pulses o_tx_done also pops the next byte.
  - Frame period is 10*CLKS_PER_BIT+1 cycles.
- Baud counter counts 0..CLKS_PER_BIT-1 and wraps at the bit boundary. Its width is clog2(CLKS_PER_BIT).
- Writes during a frame never disturb the frame in flight.
- o_busy = (state != IDLE).

Optional Feature:
- Macro UART_TX_PARITY_EN.
- When defined:
  - A PARITY state is inserted between DATA and STOP, driving even parity (XOR of the 8 data bits) for CLKS_PER_BIT cycles.
  - Frame period becomes 11*CLKS_PER_BIT+1 cycles.
- When undefined: pure 8N1 as above, with no parity logic synthesised.

Decomposition:
- Shared package uart_pkg holds:
  - the FSM state encoding;
  - DATA_BITS=8 and STOP_BITS=1;
  - a constant function clks_per_bit(clk_freq, baud).
- The same package also serves the RX path.
- One natural sub-module, uart_tx_fifo: synchronous byte FIFO with wr_en/rd_en, full/empty and count. The top holds the divider and FSM.

Test Plan:
- All scenarios use CLK_FREQ=1600, BAUD=100 (CLKS_PER_BIT=16).
- Reset then idle 100 cycles -> o_tx=1, o_empty=1, o_busy=0, o_tx_done never pulses.
- Write 8'h48 once -> o_tx low 16 cycles, then 0,0,0,1,0,0,1,0 at 16 cycles each, then high 16 cycles; o_tx_done pulses once 161 cycles after the pop; a bench UART RX model decodes 8'h48.
- Write "Hello" (48,65,6C,6C,6F) in 5 consecutive cycles -> five frames of 161 cycles each, one idle cycle between frames, model decodes the bytes in order, 5 o_tx_done pulses.
- Write 10 bytes while idle with FIFO_DEPTH=8:
  - first byte popped at once, so the next 8 fill the FIFO (o_full=1);
  - the 10th write is dropped;
  - exactly 9 bytes are transmitted.
- Assert i_reset at bit 3 of a frame with 3 bytes queued -> o_tx=1 immediately, o_empty=1, o_busy=0, no o_tx_done, nothing further transmitted.
- With UART_TX_PARITY_EN, send 8'h07 -> parity bit = 1, frame period 177 cycles.
